// File: rtl/wf_mdu_pkg.sv
// wf_mdu_pkg: op encodings, FSM states and sizing helpers shared by the multiply/divide unit.
package wf_mdu_pkg;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  localparam int WL_DEF = 4;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
  function automatic logic is_div(input op_e o);
    return o[1];
  endfunction
endpackage

// File: rtl/wf_mul_div_unit_if.sv
// wf_mul_div_unit_if: command/operand and HI/LO result bundle between execute control and the MDU.
interface wf_mul_div_unit_if #(parameter int WL = wf_mdu_pkg::WL_DEF);
  import wf_mdu_pkg::*;
  localparam int N = WL * 8;
  logic start;
  op_e op;
  logic [N-1:0] SRCA, SRCB, HI, LO;
  logic busy, done, div_by_zero;
  modport master (output start, op, SRCA, SRCB, input busy, done, div_by_zero, HI, LO);
  modport slave (input start, op, SRCA, SRCB, output busy, done, div_by_zero, HI, LO);
endinterface

// File: rtl/wf_mdu_iter_step.sv
// wf_mdu_iter_step: one shift-add (multiply) or restoring shift-subtract (divide) step on a 2N+1-bit accumulator.
module wf_mdu_iter_step #(parameter int N = 32) (
  input  logic [2*N:0] acc_i,
  input  logic [N-1:0] m_i,
  input  logic         div_i,
  output logic [2*N:0] acc_o
);
  logic [N:0] sum;
  logic [N+1:0] trial;
  always_comb begin
    sum = acc_i[2*N:N] + (acc_i[0] ? {1'b0, m_i} : '0);
    trial = {1'b0, acc_i[2*N-1:N-1]} - {2'b0, m_i};
    acc_o = !div_i ? {1'b0, sum, acc_i[N-1:1]} :
            trial[N+1] ? {acc_i[2*N-1:0], 1'b0} : {trial[N:0], acc_i[N-2:0], 1'b1};
  end
endmodule

// File: rtl/wf_mul_div_unit.sv
// wf_mul_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO result registers and N+1 cycle latency.
// Define WF_MDU_SIGNED_EN for signed MULT/DIV; otherwise op[0] is ignored and all ops are unsigned.
module wf_mul_div_unit
  import wf_mdu_pkg::*;
#(parameter int WL = WL_DEF) (
  input logic CLK,
  input logic RST,
  wf_mul_div_unit_if.slave bus
);
  localparam int N = WL * 8;
  localparam int CW = cnt_w(N);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2*N:0] acc_q, acc_n;
  logic [2*N-1:0] prod;
  logic [N-1:0] m_q, hi_q, lo_q, mag_a, mag_b, quo, rem;
  logic div_q, bz_q, busy_q, done_q, dbz_q;
`ifdef WF_MDU_SIGNED_EN
  logic sa, sb, neg_res_q, neg_rem_q;
  assign sa = bus.op[0] & bus.SRCA[N-1];
  assign sb = bus.op[0] & bus.SRCB[N-1];
  assign mag_a = sa ? -bus.SRCA : bus.SRCA;
  assign mag_b = sb ? -bus.SRCB : bus.SRCB;
  assign prod = neg_res_q ? -acc_q[2*N-1:0] : acc_q[2*N-1:0];
  assign quo = neg_res_q ? -acc_q[N-1:0] : acc_q[N-1:0];
  assign rem = neg_rem_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
`else
  assign mag_a = bus.SRCA;
  assign mag_b = bus.SRCB;
  assign prod = acc_q[2*N-1:0];
  assign quo = acc_q[N-1:0];
  assign rem = acc_q[2*N-1:N];
`endif
  // Product is commutative, so SRCA always seeds the low half and SRCB is the added/subtracted operand.
  wf_mdu_iter_step #(.N(N)) u_step (.acc_i(acc_q), .m_i(m_q), .div_i(div_q), .acc_o(acc_n));
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      m_q <= '0;
      div_q <= 1'b0;
      bz_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
`ifdef WF_MDU_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= RUN;
          cnt_q <= '0;
          acc_q <= {{(N+1){1'b0}}, mag_a};
          m_q <= mag_b;
          div_q <= is_div(bus.op);
          bz_q <= bus.SRCB == '0;
          busy_q <= 1'b1;
          dbz_q <= 1'b0;
`ifdef WF_MDU_SIGNED_EN
          neg_res_q <= sa ^ sb;
          neg_rem_q <= sa;
`endif
        end
        RUN: begin
          acc_q <= acc_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          dbz_q <= div_q & bz_q;
          hi_q <= div_q ? rem : prod[2*N-1:N];
          lo_q <= div_q ? (bz_q ? '1 : quo) : prod[N-1:0];
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.HI = hi_q;
  assign bus.LO = lo_q;
endmodule
